// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: PC generation, credit-limited imem requests, response FIFO to IF/ID
// Redirects flush the buffered path and count stale in-flight responses to be dropped.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stallD,
   output logic        validF,
   output logic [31:0] InstrF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard_cnt;
   logic [CW-1:0] fifo_count;
   logic [AW-1:0] pcq_wr, pcq_rd, fifo_wr, fifo_rd;
   logic [31:0]   pcq       [FIFO_DEPTH];
   logic [31:0]   fifo_pc   [FIFO_DEPTH];
   logic [31:0]   fifo_data [FIFO_DEPTH];

   logic [CW:0] credit_used;
   logic        issue;
   logic        rsp_drop;
   logic        fifo_push;
   logic        fifo_pop;

   // Credits cover both in-flight requests and buffered words, so a push can never find the FIFO full.
   assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = reset_n && !redirect && (credit_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;
   assign issue          = imem_req_valid && imem_req_ready;
   assign rsp_drop       = imem_rsp_valid && (discard_cnt != '0);
   assign fifo_push      = imem_rsp_valid && !rsp_drop && !redirect;
   assign validF         = (fifo_count != '0);
   assign fifo_pop       = validF && !stallD && !redirect;

   assign InstrF   = validF ? fifo_data[fifo_rd] : NOP;
   assign PCF      = validF ? fifo_pc[fifo_rd] : 32'h0;
   assign PCPlus4F = validF ? fifo_pc[fifo_rd] + 32'd4 : 32'h0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         discard_cnt <= '0;
         fifo_count  <= '0;
         pcq_wr      <= '0;
         pcq_rd      <= '0;
         fifo_wr     <= '0;
         fifo_rd     <= '0;
      end else begin
         case ({issue, imem_rsp_valid})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
         if (redirect) begin
            // Everything still in flight is older than the new path; a response landing now is dropped too.
            fetch_pc    <= redirect_pc;
            discard_cnt <= outstanding - CW'(imem_rsp_valid);
            fifo_count  <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
         end else begin
            if (issue) begin
               fetch_pc <= fetch_pc + 32'd4;
               pcq_wr   <= pcq_wr + AW'(1);
            end
            if (rsp_drop)
               discard_cnt <= discard_cnt - CW'(1);
            if (fifo_push) begin
               pcq_rd  <= pcq_rd + AW'(1);
               fifo_wr <= fifo_wr + AW'(1);
            end
            if (fifo_pop)
               fifo_rd <= fifo_rd + AW'(1);
            case ({fifo_push, fifo_pop})
               2'b10:   fifo_count <= fifo_count + CW'(1);
               2'b01:   fifo_count <= fifo_count - CW'(1);
               default: fifo_count <= fifo_count;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (issue)
         pcq[pcq_wr] <= fetch_pc;
      if (fifo_push) begin
         fifo_pc[fifo_wr]   <= pcq[pcq_rd];
         fifo_data[fifo_wr] <= imem_rsp_data;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with an in-order instruction memory model
module tb_fetch_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        stallD = 1'b0;
   logic        validF;
   logic [31:0] InstrF, PCF, PCPlus4F;

   logic        mem_hold = 1'b0;
   logic [31:0] mq [$];
   bit          overflow_seen = 1'b0;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .stallD(stallD),
      .validF(validF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
   );

   function automatic logic [31:0] image(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5A5, a[15:0]};
   endfunction

   always @(posedge clk)
      if (reset_n && imem_req_valid && imem_req_ready) mq.push_back(imem_req_addr);

   always @(posedge clk)
      if (reset_n && dut.fifo_push && dut.fifo_count == DEPTH) overflow_seen = 1'b1;

   always @(negedge clk) begin
      if (!reset_n) begin
         mq.delete();
         imem_rsp_valid = 1'b0;
      end else if (!mem_hold && mq.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = image(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; stallD = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; mem_hold = 1'b0;
      step(); step();
      reset_n = 1'b1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (validF) begin ok = 1'b1; break; end
         step();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
      vectors++; if (validF !== 1'b0) begin miscompares++; $display("FAIL reset_validF got %b want 0", validF); end
      vectors++; if (InstrF !== 32'h13) begin miscompares++; $display("FAIL reset_InstrF got %h want 00000013", InstrF); end
      vectors++; if (PCF !== 32'h0 || PCPlus4F !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h/%h want 0/0", PCF, PCPlus4F); end
      step();
      reset_n = 1'b1;
      #1;
      vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL first_req got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_linear();
      logic [31:0] exp_pc [4];
      bit ok;
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         wait_valid(20, ok);
         vectors++;
         if (!ok) begin miscompares++; $display("FAIL linear_timeout idx %0d got no validF want validF", k); end
         else if (PCF !== exp_pc[k] || PCPlus4F !== exp_pc[k] + 32'd4 || InstrF !== image(exp_pc[k])) begin
            miscompares++;
            $display("FAIL linear idx %0d got pc=%h pc4=%h instr=%h want pc=%h pc4=%h instr=%h",
                     k, PCF, PCPlus4F, InstrF, exp_pc[k], exp_pc[k] + 32'd4, image(exp_pc[k]));
         end
         step();
      end
   endtask

   task automatic test_stall();
      do_reset();
      stallD = 1'b1;
      repeat (6) step();
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (validF !== 1'b1 || PCF !== 32'h0 || InstrF !== image(32'h0) || imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_hold cyc %0d got v=%b pc=%h instr=%h req=%b want v=1 pc=0 instr=%h req=0",
                     k, validF, PCF, InstrF, imem_req_valid, image(32'h0));
         end
         step();
      end
      vectors++; if (overflow_seen !== 1'b0) begin miscompares++; $display("FAIL fifo_overflow got 1 want 0"); end
      stallD = 1'b0;
      vectors++; if (PCF !== 32'h0 || validF !== 1'b1) begin miscompares++; $display("FAIL stall_release0 got v=%b pc=%h want v=1 pc=0", validF, PCF); end
      step();
      vectors++;
      if (validF !== 1'b1 || PCF !== 32'h4 || InstrF !== image(32'h4)) begin
         miscompares++;
         $display("FAIL stall_release1 got v=%b pc=%h instr=%h want v=1 pc=4 instr=%h", validF, PCF, InstrF, image(32'h4));
      end
   endtask

   task automatic test_redirect_outstanding();
      bit ok;
      do_reset();
      mem_hold = 1'b1;
      step(); step();
      vectors++; if (dut.outstanding !== 2) begin miscompares++; $display("FAIL redir_outstanding got %0d want 2", dut.outstanding); end
      redirect = 1'b1; redirect_pc = 32'h100;
      step();
      redirect = 1'b0; mem_hold = 1'b0;
      vectors++; if (dut.discard_cnt !== 2) begin miscompares++; $display("FAIL redir_discard got %0d want 2", dut.discard_cnt); end
      wait_valid(30, ok);
      vectors++;
      if (!ok || PCF !== 32'h100 || PCPlus4F !== 32'h104 || InstrF !== image(32'h100)) begin
         miscompares++;
         $display("FAIL redir_first got ok=%b pc=%h pc4=%h instr=%h want pc=100 pc4=104 instr=%h", ok, PCF, PCPlus4F, InstrF, image(32'h100));
      end
   endtask

   task automatic test_redirect_coincident();
      bit ok;
      do_reset();
      mem_hold = 1'b1;
      step(); step();
      redirect = 1'b1; redirect_pc = 32'h200; mem_hold = 1'b0;
      step();
      redirect = 1'b0;
      vectors++; if (dut.discard_cnt !== 1) begin miscompares++; $display("FAIL coinc_discard got %0d want 1", dut.discard_cnt); end
      vectors++; if (validF !== 1'b0) begin miscompares++; $display("FAIL coinc_dropped got validF=%b want 0", validF); end
      wait_valid(30, ok);
      vectors++;
      if (!ok || PCF !== 32'h200 || InstrF !== image(32'h200)) begin
         miscompares++;
         $display("FAIL coinc_first got ok=%b pc=%h instr=%h want pc=200 instr=%h", ok, PCF, InstrF, image(32'h200));
      end
   endtask

   task automatic test_backpressure_wrap();
      bit ok;
      do_reset();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect = 1'b0;
      wait_valid(30, ok);
      vectors++;
      if (!ok || PCF !== 32'hFFFF_FFFC || PCPlus4F !== 32'h0 || InstrF !== image(32'hFFFF_FFFC)) begin
         miscompares++;
         $display("FAIL wrap_top got ok=%b pc=%h pc4=%h instr=%h want pc=fffffffc pc4=0 instr=%h", ok, PCF, PCPlus4F, InstrF, image(32'hFFFF_FFFC));
      end
      step();
      wait_valid(30, ok);
      vectors++;
      if (!ok || PCF !== 32'h0 || PCPlus4F !== 32'h4) begin
         miscompares++;
         $display("FAIL wrap_next got ok=%b pc=%h pc4=%h want pc=0 pc4=4", ok, PCF, PCPlus4F);
      end
      redirect = 1'b1; redirect_pc = 32'h40; imem_req_ready = 1'b0;
      step();
      redirect = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 4; k++) begin
         vectors++;
         if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || validF !== 1'b0 || InstrF !== 32'h13) begin
            miscompares++;
            $display("FAIL bp_hold cyc %0d got req=%b addr=%h v=%b instr=%h want req=1 addr=40 v=0 instr=00000013",
                     k, imem_req_valid, imem_req_addr, validF, InstrF);
         end
         step();
      end
      imem_req_ready = 1'b1;
      wait_valid(30, ok);
      vectors++;
      if (!ok || PCF !== 32'h40 || InstrF !== image(32'h40)) begin
         miscompares++;
         $display("FAIL bp_release got ok=%b pc=%h instr=%h want pc=40 instr=%h", ok, PCF, InstrF, image(32'h40));
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_reset();
      stallD = 1'b1;
      step(); step();
      vectors++;
      if (validF !== 1'b1 || dut.outstanding !== 1) begin
         miscompares++;
         $display("FAIL mid_setup got v=%b outstanding=%0d want v=1 outstanding=1", validF, dut.outstanding);
      end
      reset_n = 1'b0;
      #1;
      vectors++;
      if (validF !== 1'b0 || InstrF !== 32'h13 || PCF !== 32'h0 || PCPlus4F !== 32'h0 || imem_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL mid_reset got v=%b instr=%h pc=%h pc4=%h req=%b want v=0 instr=00000013 pc=0 pc4=0 req=0",
                  validF, InstrF, PCF, PCPlus4F, imem_req_valid);
      end
      step(); step();
      stallD = 1'b0; reset_n = 1'b1;
      #1;
      vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL mid_restart got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
      wait_valid(30, ok);
      vectors++;
      if (!ok || PCF !== 32'h0 || InstrF !== image(32'h0)) begin
         miscompares++;
         $display("FAIL mid_first got ok=%b pc=%h instr=%h want pc=0 instr=%h", ok, PCF, InstrF, image(32'h0));
      end
      step();
      wait_valid(30, ok);
      vectors++;
      if (!ok || PCF !== 32'h4 || InstrF !== image(32'h4)) begin
         miscompares++;
         $display("FAIL mid_second got ok=%b pc=%h instr=%h want pc=4 instr=%h", ok, PCF, InstrF, image(32'h4));
      end
   endtask

   initial begin
      test_reset();
      test_linear();
      test_stall();
      test_redirect_outstanding();
      test_redirect_coincident();
      test_backpressure_wrap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Producer side of the IF/ID stage register. Generates the fetch-stage values InstrF, PCF and PCPlus4F that the decode register captures.
- Owns the fetch PC and issues in-order requests over a valid/ready instruction-memory port. Buffers responses in a small FIFO.
- Honours decode stall (IF/ID enable low) and branch/jump redirects. In-flight responses older than a redirect are discarded.
- When no instruction is buffered, presents a NOP bubble (0x00000013).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, instruction buffer entries and maximum credits. Power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  request byte address, word aligned
- imem_rsp_valid  in  1  response valid; in order; no backpressure
- imem_rsp_data  in  32  response instruction word
- redirect  in  1  branch/jump taken; flush the fetch path
- redirect_pc  in  32  new fetch address
- stallD  in  1  decode register not enabled this cycle
- validF  out  1  InstrF/PCF/PCPlus4F hold a real instruction
- InstrF  out  32  instruction to decode register
- PCF  out  32  PC of InstrF
- PCPlus4F  out  32  PCF + 4, modulo 2^32

Behaviour:
- Reset (async, any time, including mid-transaction) clears:
  - FIFO, in-flight PC queue, outstanding counter and discard counter.
  - fetch_pc <= RESET_PC.
- Outputs during reset: imem_req_valid=0, validF=0, InstrF=0x13, PCF=0, PCPlus4F=0.
- Issue:
  - imem_req_valid=1 when redirect=0 and (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_req_addr = fetch_pc.
  - Handshake occurs when valid && ready. On handshake: fetch_pc += 4 (wraps at 2^32), outstanding++, fetch_pc pushed to the in-flight PC queue.
  - While valid && !ready, addr and valid are held stable. The only exception is a redirect, which withdraws the request.
- First request is visible in the first cycle after reset deasserts.
- Response, when imem_rsp_valid=1:
  - outstanding--.
  - If discard_cnt > 0: discard_cnt--, word dropped, PC queue not popped.
  - Otherwise: {pc, pc+4, data} pushed to FIFO and PC queue popped.
  - Simultaneous issue and response updates outstanding by net 0.
- Latency: a response accepted in cycle N appears on the outputs in cycle N+1. There is no bypass.
- Output: the FIFO head drives InstrF/PCF/PCPlus4F with validF=1.
  - Empty FIFO: validF=0, InstrF=0x13, PCF=0, PCPlus4F=0.
  - Pop when validF && !stallD.
  - stallD=1 holds the head unchanged for any number of cycles.
- Redirect in cycle N has priority over every other event in cycle N:
  - imem_req_valid=0 (no handshake in cycle N); fetch_pc <= redirect_pc.
  - FIFO and PC queue flushed; no pop.
  - discard_cnt <= outstanding minus imem_rsp_valid. A response arriving in cycle N is itself dropped.
  - First request to redirect_pc is issued in cycle N+1 if credit allows. Responses are delivered only after all discards are consumed.
- Back-to-back redirects: the last one wins. discard_cnt is recomputed each time.
- Credit rule: the FIFO can never overflow. A push with a full FIFO is impossible by construction; the bench asserts this.
- imem_req_addr[1:0] is always 0 for aligned RESET_PC/redirect_pc. Misaligned redirect_pc is passed through unchecked.

Test Plan:
- Linear fetch: RESET_PC=0, imem_req_ready=1, response 1 cycle after each request → PCF sequence 0,4,8,C with PCPlus4F=PCF+4 and InstrF matching the memory image.
- Stall: stallD=1 for 5 cycles with FIFO full (2 entries) → outputs constant, imem_req_valid=0, no FIFO overflow. After release, both entries delivered in order, 1 per cycle.
- Redirect with 2 outstanding: redirect=1, redirect_pc=0x100 while 2 requests are in flight → the next 2 responses are dropped and the first validF=1 output has PCF=0x100.
- Redirect coincident with response → that response is dropped, discard_cnt = outstanding−1, and fetch resumes at redirect_pc.
- Memory backpressure: imem_req_ready=0 for 4 cycles → addr held stable, validF=0, InstrF=0x13. Wrap case: redirect_pc=0xFFFFFFFC → PCPlus4F=0, next fetch address 0.
- Reset mid-operation: reset_n low while 1 request is outstanding and the FIFO is non-empty → outputs revert to NOP immediately. After release, fetch restarts at RESET_PC and the stale response is ignored (memory model also reset).
